perf_counter_sampler: RTL and testbench

Reader/collector for the saturating performance counter bank. It sweeps the bank's counter select, captures all counters into a snapshot, and computes the per-counter delta since the previous snapshot. It then streams {index, value, delta} records over a valid/ready interface to the debug/trace path. A sweep is started either by a programmable periodic timer or by a one-cycle manual trigger.

---
 rtl/perf_counter_sampler_if.sv | 31 +++
 rtl/perf_counter_sampler.sv | 145 ++++++++++++++
 tb/tb_perf_counter_sampler.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_sampler_if.sv
// Record stream from the performance counter sampler to the debug/trace path.
// The master drives {idx, value, delta, last} under a valid/ready handshake.
interface perf_counter_sampler_if #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned CNT_W = 64
);
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_idx;
    logic [CNT_W-1:0] out_value;
    logic [CNT_W-1:0] out_delta;
    logic             out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_value,
        output out_delta,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_value,
        input  out_delta,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/perf_counter_sampler.sv
// Sweeps the counter bank into a snapshot and streams {index, value, delta}
// records; sweeps start from a periodic timer or a manual trigger.
module perf_counter_sampler #(
    parameter int unsigned NUM_COUNTERS = 9,
    parameter int unsigned SEL_W        = 4,
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned PERIOD_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    input  logic                          trigger,
    output logic [SEL_W-1:0]              sel,
    input  logic [CNT_W-1:0]              counter_val,
    perf_counter_sampler_if.master        out,
    output logic                          busy,
    output logic [15:0]                   overrun_cnt
);

    typedef enum logic [1:0] {StIdle, StSweep, StEmit} state_e;

    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_COUNTERS - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                out_valid_q, out_valid_d;
    logic [PERIOD_W-1:0] tcnt_q;
    logic [15:0]         overrun_q;
    logic                timer_on, timer_req, req, capture, accept;
    logic [CNT_W-1:0]    snap_q [NUM_COUNTERS];
    logic [CNT_W-1:0]    prev_q [NUM_COUNTERS];
    logic [CNT_W-1:0]    cur_val, prev_val;

    assign timer_on  = enable && (period != '0);
    assign timer_req = timer_on && (tcnt_q >= period - PERIOD_W'(1));
    assign req       = trigger | timer_req;
    assign accept    = out_valid_q && out.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if (!timer_on || timer_req) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + PERIOD_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                capture = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d     = StEmit;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            StEmit: begin
                if (accept) begin
                    if (idx_q == LastIdx) begin
                        state_d     = StIdle;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
        // The bank select only moves while sweeping; it parks at 0 otherwise.
        sel_d = (state_d == StSweep) ? idx_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                snap_q[i] <= '0;
                prev_q[i] <= '0;
            end
        end else begin
            if (capture) begin
                snap_q[idx_q] <= counter_val;
            end
            // The baseline only advances once the record has been delivered.
            if (accept) begin
                prev_q[idx_q] <= snap_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= '0;
        end else if (req && (state_q != StIdle) && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign cur_val  = snap_q[idx_q];
    assign prev_val = prev_q[idx_q];

    assign sel           = sel_q;
    assign busy          = (state_q != StIdle);
    assign overrun_cnt   = overrun_q;
    assign out.out_valid = out_valid_q;
    assign out.out_idx   = idx_q;
    assign out.out_value = cur_val;
    assign out.out_delta = (cur_val >= prev_val) ? (cur_val - prev_val) : '0;
    assign out.out_last  = out_valid_q && (idx_q == LastIdx);

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Bench for perf_counter_sampler: directed record tables plus a randomized run
// checked cycle by cycle against a queue-based reference model.
module tb_perf_counter_sampler;

    localparam int N = 9;

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] value;
        logic [63:0] delta;
        logic        last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] period;
    logic        trigger;
    logic [3:0]  sel;
    logic [63:0] counter_val;
    logic        busy;
    logic [15:0] overrun_cnt;
    logic [63:0] bank [N];

    int tests = 0;
    int fails = 0;

    perf_counter_sampler_if #(.SEL_W(4), .CNT_W(64)) bus ();

    perf_counter_sampler #(
        .NUM_COUNTERS(N),
        .SEL_W       (4),
        .CNT_W       (64),
        .PERIOD_W    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .trigger    (trigger),
        .sel        (sel),
        .counter_val(counter_val),
        .out        (bus.master),
        .busy       (busy),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        counter_val = 64'd0;
        if (sel < 4'd9) counter_val = bank[sel];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: a sweep is a batch of N expected records queued when an
    // accepted request is seen; the batch becomes visible N+1 cycles later.
    vec_t        exp_q[$];
    logic [63:0] m_prev [N];
    logic [31:0] m_tcnt;
    int          m_wait;
    logic [15:0] m_ovr;
    logic        m_busy, m_on, m_treq, m_req;
    logic [3:0]  m_exp_sel;
    vec_t        m_rec;
    logic        st_valid;
    vec_t        st_rec;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < N; i++) m_prev[i] = 64'd0;
            m_tcnt   = 32'd0;
            m_wait   = 0;
            m_ovr    = 16'd0;
            st_valid = 1'b0;
        end else begin
            m_busy = (exp_q.size() != 0);
            if (m_wait != 0) m_wait--;
            m_exp_sel = (m_busy && m_wait >= 1 && m_wait <= N) ? 4'(N - m_wait) : 4'd0;
            check("sel", sel, m_exp_sel);
            check("busy", busy, m_busy);
            check("out_valid", bus.out_valid, m_busy && (m_wait == 0));
            check("overrun_cnt", overrun_cnt, m_ovr);
            if (st_valid && bus.out_valid) begin
                check("stall idx", bus.out_idx, st_rec.idx);
                check("stall value", bus.out_value, st_rec.value);
                check("stall delta", bus.out_delta, st_rec.delta);
                check("stall last", bus.out_last, st_rec.last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL record: got idx %0d, required no record", bus.out_idx);
                end else begin
                    m_rec = exp_q.pop_front();
                    check("rec idx", bus.out_idx, m_rec.idx);
                    check("rec value", bus.out_value, m_rec.value);
                    check("rec delta", bus.out_delta, m_rec.delta);
                    check("rec last", bus.out_last, m_rec.last);
                    m_prev[m_rec.idx] = m_rec.value;
                end
            end
            st_valid = bus.out_valid && !bus.out_ready;
            st_rec   = '{bus.out_idx, bus.out_value, bus.out_delta, bus.out_last};
            m_on   = enable && (period != 32'd0);
            m_treq = m_on && (m_tcnt >= period - 32'd1);
            m_tcnt = (!m_on || m_treq) ? 32'd0 : m_tcnt + 32'd1;
            m_req  = trigger || m_treq;
            if (m_req) begin
                if (m_busy) begin
                    if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        m_rec.idx   = 4'(i);
                        m_rec.value = bank[i];
                        m_rec.delta = (bank[i] >= m_prev[i]) ? bank[i] - m_prev[i] : 64'd0;
                        m_rec.last  = (i == N - 1);
                        exp_q.push_back(m_rec);
                    end
                    m_wait = N + 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("reset sel", sel, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun_cnt", overrun_cnt, 0);
        check("reset out_idx", bus.out_idx, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset out_value", bus.out_value, 0);
        check("reset out_delta", bus.out_delta, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_trigger();
        @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic wait_hs();
        int n = 0;
        while (!(bus.out_valid && bus.out_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL handshake: got none in %0d cycles, required a record", n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL idle: got %0d records pending, required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    vec_t vecs [2*N];

    initial begin
        int lat;
        rst           = 1'b1;
        enable        = 1'b0;
        period        = 32'd0;
        trigger       = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bank[i]     = 64'(100 * i + 5);
            vecs[i]     = '{4'(i), 64'(100 * i + 5), 64'(100 * i + 5), (i == N - 1)};
            vecs[N + i] = '{4'(i), 64'(100 * i + 8), 64'd3, (i == N - 1)};
        end
        do_reset();

        // Two manual sweeps: first delta equals value, second sees +3 everywhere.
        for (int s = 0; s < 2; s++) begin
            if (s == 1) for (int i = 0; i < N; i++) bank[i] = bank[i] + 64'd3;
            pulse_trigger();
            lat = 0;
            while (!bus.out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check("first valid latency", 64'(lat), 64'(N + 1));
            for (int k = 0; k < N; k++) begin
                wait_hs();
                check("tbl idx", bus.out_idx, vecs[s*N + k].idx);
                check("tbl value", bus.out_value, vecs[s*N + k].value);
                check("tbl delta", bus.out_delta, vecs[s*N + k].delta);
                check("tbl last", bus.out_last, vecs[s*N + k].last);
                @(posedge clk);
                #1;
            end
            wait_idle();
        end

        // Periodic sweeps every 20 cycles.
        @(posedge clk);
        #1 period = 32'd20;
        enable = 1'b1;
        repeat (100) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle();
        check("periodic overrun", overrun_cnt, 0);

        // Trigger in the same cycle the timer fires: one sweep, no overrun.
        @(posedge clk);
        #1 period = 32'd60;
        enable = 1'b1;
        repeat (59) @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        enable = 1'b0;
        wait_idle();
        check("simultaneous overrun", overrun_cnt, 0);

        // Saturated counters across two sweeps.
        bank[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        bank[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        pulse_trigger();
        wait_idle();
        pulse_trigger();
        for (int k = 0; k < N; k++) begin
            wait_hs();
            if (bus.out_idx == 4'd2 || bus.out_idx == 4'd5) check("sat delta", bus.out_delta, 0);
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Randomized run: stalls, triggers, timer, bank updates between sweeps.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 9) < 6);
            trigger       = ($urandom_range(0, 24) == 0);
            if (c == 500) begin
                enable = 1'b1;
                period = 32'($urandom_range(12, 40));
            end
            if (c == 1100) period = 32'd0;
            if (exp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 3))
                        0: bank[i] = {$urandom, $urandom};
                        1: bank[i] = 64'hFFFF_FFFF_FFFF_FFFF;
                        default: bank[i] = bank[i] + 64'($urandom_range(0, 1000));
                    endcase
                end
            end
        end
        @(posedge clk);
        #1 trigger = 1'b0;
        enable        = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        // Requests while stalled in EMIT are dropped and counted; then reset mid-EMIT.
        do_reset();
        bus.out_ready = 1'b0;
        pulse_trigger();
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        repeat (3) pulse_trigger();
        @(negedge clk);
        check("overrun after 3 drops", overrun_cnt, 3);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid-emit rst out_valid", bus.out_valid, 0);
        check("mid-emit rst sel", sel, 0);
        check("mid-emit rst busy", busy, 0);
        check("mid-emit rst overrun", overrun_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        pulse_trigger();
        wait_hs();
        check("post-reset idx", bus.out_idx, 0);
        check("post-reset delta", bus.out_delta, bank[0]);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
